// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared definitions for the program-counter control stage.
//   - state_t           : fetch-control FSM states (BOOT, RUN, REDIRECT, TRAP)
//   - INSN_STEP         : sequential fetch increment in bytes
//   - DEFAULT_RESET_VEC : default PC loaded on reset
//   - resolve_f         : whether the EX instruction redirects fetch
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    REDIRECT = 2'd2,
    TRAP     = 2'd3
  } state_t;

  localparam logic [31:0] INSN_STEP         = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  // A valid EX instruction redirects fetch when it is a taken branch or any jump.
  function automatic logic resolve_f(input logic ex_valid, input logic branch,
                                     input logic taken, input logic jump);
    return ex_valid && ((branch && taken) || jump);
  endfunction

endpackage

// File: rtl/pc_target.sv
// pc_target: combinational redirect-target computation.
//   jalr       in  : select register-relative (JALR) form
//   ex_pc      in  : PC of the EX instruction
//   ex_imm     in  : sign-extended immediate
//   ex_rs1     in  : rs1 operand for JALR
//   target     out : redirect address (JALR form has bit 0 cleared)
//   misaligned out : target is not 4-byte aligned (bit 1 set)
module pc_target
  import pc_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] sum_s;

  // Modular add of base and immediate; JALR clears the LSB of the sum.
  always_comb begin
    sum_s      = {XLEN{1'b0}};
    target     = {XLEN{1'b0}};
    misaligned = 1'b0;
    if (jalr) begin
      sum_s  = ex_rs1 + ex_imm;
      target = {sum_s[XLEN-1:1], 1'b0};
    end else begin
      sum_s  = ex_pc + ex_imm;
      target = sum_s;
    end
    // Bit 0 is even by construction (JALR clears it, other immediates are even),
    // so only bit 1 can make the target misaligned.
    misaligned = target[1];
  end

endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: program-counter control stage.
// Holds the fetch PC, advances it by 4 per accepted fetch, redirects on a taken
// branch or jump resolved in EX (one-cycle flush plus one bubble), and halts
// fetch with a sticky trap on a misaligned target.
// Optional feature (macro PC_PERF_CNT_EN): branch and taken-branch counters.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   pc, pc_valid    : fetch address and request valid
//   pc_ready        : fetch memory accepts pc
//   stall           : hold sequential advance
//   ex_valid, branch, taken, jump, jalr : EX control inputs
//   ex_pc, ex_imm, ex_rs1               : EX operands for target
//   flush           : kill IF/ID contents (one cycle)
//   misalign        : sticky instruction-address-misaligned trap
//   br_cnt, br_taken_cnt (PC_PERF_CNT_EN only) : branch counters
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            branch,
  input  logic            taken,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  output logic            flush,
  output logic            misalign
`ifdef PC_PERF_CNT_EN
  ,
  output logic [31:0]     br_cnt,
  output logic [31:0]     br_taken_cnt
`endif
);

  state_t          state_r;
  logic            resolve_s;
  logic [XLEN-1:0] target_s;
  logic            misaligned_s;

  assign resolve_s = resolve_f(ex_valid, branch, taken, jump);

  pc_target #(.XLEN(XLEN)) u_pc_target (
    .jalr       (jalr),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_rs1     (ex_rs1),
    .target     (target_s),
    .misaligned (misaligned_s)
  );

  // Fetch-control FSM with registered pc, pc_valid, flush and misalign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= BOOT;
      pc       <= RESET_VEC;
      pc_valid <= 1'b0;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      case (state_r)
        BOOT: begin
          state_r  <= RUN;
          pc_valid <= 1'b1;
          flush    <= 1'b0;
        end
        RUN: begin
          if (resolve_s && misaligned_s) begin
            // Trap keeps the current pc; fetch stops for good.
            state_r  <= TRAP;
            misalign <= 1'b1;
            flush    <= 1'b1;
            pc_valid <= 1'b0;
          end else if (resolve_s) begin
            // Redirect wins over stall and pc_ready.
            state_r  <= REDIRECT;
            pc       <= target_s;
            flush    <= 1'b1;
            pc_valid <= 1'b0;
          end else if (pc_ready && !stall) begin
            pc       <= pc + XLEN'(INSN_STEP);
            flush    <= 1'b0;
          end else begin
            flush    <= 1'b0;
          end
        end
        REDIRECT: begin
          // Bubble cycle: the EX instruction is being flushed, so resolve is ignored.
          state_r  <= RUN;
          flush    <= 1'b0;
          pc_valid <= 1'b1;
        end
        TRAP: begin
          flush    <= 1'b0;
          pc_valid <= 1'b0;
          misalign <= 1'b1;
        end
        default: begin
          state_r  <= BOOT;
          flush    <= 1'b0;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_PERF_CNT_EN
  // Branch statistics, counted only while fetch is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt       <= 32'd0;
      br_taken_cnt <= 32'd0;
    end else if ((state_r == RUN) && ex_valid && branch) begin
      br_cnt <= br_cnt + 32'd1;
      if (taken) begin
        br_taken_cnt <= br_taken_cnt + 32'd1;
      end else begin
        br_taken_cnt <= br_taken_cnt;
      end
    end else begin
      br_cnt       <= br_cnt;
      br_taken_cnt <= br_taken_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed self-checking bench for pc_ctrl.
// A behavioural model tracks expected outputs; a compare process checks every
// falling edge, and directed steps pin literal expectations.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready = 1'b1;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic        branch = 1'b0;
  logic        taken = 1'b0;
  logic        jump = 1'b0;
  logic        jalr = 1'b0;
  logic [31:0] ex_pc = 32'd0;
  logic [31:0] ex_imm = 32'd0;
  logic [31:0] ex_rs1 = 32'd0;
  logic        flush;
  logic        misalign;
`ifdef PC_PERF_CNT_EN
  logic [31:0] br_cnt;
  logic [31:0] br_taken_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pc_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .pc_valid (pc_valid),
    .pc_ready (pc_ready),
    .stall    (stall),
    .ex_valid (ex_valid),
    .branch   (branch),
    .taken    (taken),
    .jump     (jump),
    .jalr     (jalr),
    .ex_pc    (ex_pc),
    .ex_imm   (ex_imm),
    .ex_rs1   (ex_rs1),
    .flush    (flush),
    .misalign (misalign)
`ifdef PC_PERF_CNT_EN
    ,
    .br_cnt       (br_cnt),
    .br_taken_cnt (br_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  bit          m_booting, m_bubble, m_trapped, m_flush;
  int unsigned m_br, m_tk;

  function automatic logic [31:0] m_target();
    logic [31:0] s;
    if (jalr) begin
      s = ex_rs1 + ex_imm;
      return s & 32'hFFFF_FFFE;
    end
    return ex_pc + ex_imm;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_booting <= 1'b1; m_bubble <= 1'b0;
      m_trapped <= 1'b0; m_flush <= 1'b0; m_br <= 0; m_tk <= 0;
    end else begin
      m_flush <= 1'b0;
      if (m_trapped) begin
        m_trapped <= 1'b1;
      end else if (m_booting) begin
        m_booting <= 1'b0;
      end else if (m_bubble) begin
        m_bubble <= 1'b0;
      end else begin
        if (ex_valid && branch) begin
          m_br <= m_br + 1;
          if (taken) m_tk <= m_tk + 1;
        end
        if (ex_valid && ((branch && taken) || jump)) begin
          m_flush <= 1'b1;
          if (m_target() % 4 != 0) m_trapped <= 1'b1;
          else begin m_pc <= m_target(); m_bubble <= 1'b1; end
        end else if (pc_ready && !stall) begin
          m_pc <= m_pc + 32'd4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("pc", pc, m_pc);
      chk("pc_valid", {31'd0, pc_valid}, {31'd0, !(m_booting || m_bubble || m_trapped)});
      chk("flush", {31'd0, flush}, {31'd0, m_flush});
      chk("misalign", {31'd0, misalign}, {31'd0, m_trapped});
`ifdef PC_PERF_CNT_EN
      chk("br_cnt", br_cnt, m_br);
      chk("br_taken_cnt", br_taken_cnt, m_tk);
`endif
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clr_ex();
    ex_valid = 1'b0; branch = 1'b0; taken = 1'b0; jump = 1'b0; jalr = 1'b0;
  endtask

  task automatic lit(input string name, input logic [31:0] epc, input logic ev,
                     input logic ef, input logic em);
    chk({name, ".pc"}, pc, epc);
    chk({name, ".valid"}, {31'd0, pc_valid}, {31'd0, ev});
    chk({name, ".flush"}, {31'd0, flush}, {31'd0, ef});
    chk({name, ".misalign"}, {31'd0, misalign}, {31'd0, em});
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    chk_en = 1'b1;
    // Boot then sequential fetch.
    cyc(); lit("boot", 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(); lit("seq0", 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(); lit("seq4", 32'h4, 1'b1, 1'b0, 1'b0);
    cyc(); lit("seq8", 32'h8, 1'b1, 1'b0, 1'b0);
    cyc(); lit("seq12", 32'hC, 1'b1, 1'b0, 1'b0);
    // Taken branch backwards.
    ex_valid = 1'b1; branch = 1'b1; taken = 1'b1; ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF0;
    cyc(); clr_ex(); lit("br_redir", 32'hF0, 1'b0, 1'b1, 1'b0);
    cyc(); lit("br_bubble_end", 32'hF0, 1'b1, 1'b0, 1'b0);
    cyc(); lit("br_adv", 32'hF4, 1'b1, 1'b0, 1'b0);
    // Not-taken branch.
    ex_valid = 1'b1; branch = 1'b1; taken = 1'b0;
    cyc(); clr_ex(); lit("nt", 32'hF8, 1'b1, 1'b0, 1'b0);
    cyc(); lit("nt2", 32'hFC, 1'b1, 1'b0, 1'b0);
    // JALR under stall.
    stall = 1'b1; ex_valid = 1'b1; jump = 1'b1; jalr = 1'b1; ex_rs1 = 32'h2001; ex_imm = 32'h4;
    cyc(); clr_ex(); lit("jalr", 32'h2004, 1'b0, 1'b1, 1'b0);
    cyc(); lit("jalr_stall", 32'h2004, 1'b1, 1'b0, 1'b0);
    stall = 1'b0;
    cyc(); lit("jalr_adv", 32'h2008, 1'b1, 1'b0, 1'b0);
    // ex_valid=0 masks everything, even a would-be misaligned jump.
    branch = 1'b1; taken = 1'b1; jump = 1'b1; ex_pc = 32'h0; ex_imm = 32'h6;
    cyc(); clr_ex(); lit("masked", 32'h200C, 1'b1, 1'b0, 1'b0);
    // Jump near top of address space, then wrap.
    ex_valid = 1'b1; jump = 1'b1; ex_pc = 32'h0; ex_imm = 32'hFFFF_FFF8;
    cyc(); clr_ex(); lit("jal_hi", 32'hFFFF_FFF8, 1'b0, 1'b1, 1'b0);
    cyc(); lit("hi_run", 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0);
    cyc(); lit("hi_top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    cyc(); lit("wrap", 32'h0, 1'b1, 1'b0, 1'b0);
    // Fetch not accepted: pc holds.
    pc_ready = 1'b0;
    cyc(); lit("hold", 32'h0, 1'b1, 1'b0, 1'b0);
    pc_ready = 1'b1;
    // Third branch, taken forward.
    ex_valid = 1'b1; branch = 1'b1; taken = 1'b1; ex_pc = 32'h0; ex_imm = 32'h40;
    cyc(); clr_ex(); lit("br3", 32'h40, 1'b0, 1'b1, 1'b0);
    cyc(); lit("br3_run", 32'h40, 1'b1, 1'b0, 1'b0);
`ifdef PC_PERF_CNT_EN
    chk("perf_br", br_cnt, 32'd3);
    chk("perf_taken", br_taken_cnt, 32'd2);
`endif
    // Misaligned JAL traps; pc stays at the fetch address of that cycle (0x40).
    ex_valid = 1'b1; jump = 1'b1; ex_pc = 32'h0; ex_imm = 32'h6;
    cyc(); clr_ex(); lit("trap_entry", 32'h40, 1'b0, 1'b1, 1'b1);
    // Resolves during trap are ignored.
    ex_valid = 1'b1; branch = 1'b1; taken = 1'b1; ex_imm = 32'h100;
    for (int i = 0; i < 10; i++) begin
      cyc(); lit("trap_hold", 32'h40, 1'b0, 1'b0, 1'b1);
    end
    clr_ex();
    // Asynchronous reset pulse mid-trap.
    #3 rst = 1'b1;
    #1 lit("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    cyc(); lit("reboot", 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(); lit("reboot_run", 32'h0, 1'b1, 1'b0, 1'b0);
    cyc(); lit("reboot_adv", 32'h4, 1'b1, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
